// File: rtl/define_state.sv
// Shared types and constants for the decode sequencer: FSM states, stage
// indices, SRAM region bases and the shared SRAM port payload.
package define_state;

  localparam int unsigned NUM_STAGES = 3;
  localparam int unsigned ADDR_W     = 18;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned TIMER_W    = 24;
  localparam int unsigned GAP_W      = 4;

  typedef enum logic [2:0] {
    S_SEQ_IDLE,
    S_SEQ_LAUNCH,
    S_SEQ_WAIT,
    S_SEQ_GAP,
    S_SEQ_DONE,
    S_SEQ_ERROR
  } seq_state_t;

  localparam logic [1:0] STG_M3   = 2'd0;
  localparam logic [1:0] STG_M2   = 2'd1;
  localparam logic [1:0] STG_M1   = 2'd2;
  localparam logic [1:0] STG_NONE = 2'd3;

  // Frame buffer layout: Y plane, U and V planes, then RGB output.
  localparam logic [ADDR_W-1:0] SRAM_Y_BASE   = 18'd0;
  localparam logic [ADDR_W-1:0] SRAM_U_BASE   = 18'd38400;
  localparam logic [ADDR_W-1:0] SRAM_V_BASE   = 18'd57600;
  localparam logic [ADDR_W-1:0] SRAM_RGB_BASE = 18'd146944;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              we_n;
  } sram_port_t;

  function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [1:0] sel);
    return NUM_STAGES'(3'b001 << sel);
  endfunction

endpackage

// File: rtl/sram_port_mux.sv
// 3:1 SRAM port selector; releases the bus (we_n high, zeros) when no stage is active.
module sram_port_mux
  import define_state::*;
(
  input  logic [1:0]                         sel,
  input  logic [NUM_STAGES-1:0][ADDR_W-1:0]  stage_address,
  input  logic [NUM_STAGES-1:0][DATA_W-1:0]  stage_write_data,
  input  logic [NUM_STAGES-1:0]              stage_we_n,
  output sram_port_t                         sram_c
);

  always_comb begin
    sram_c.address    = '0;
    sram_c.write_data = '0;
    sram_c.we_n       = 1'b1;
    if (sel != STG_NONE) begin
      sram_c.address    = stage_address[sel];
      sram_c.write_data = stage_write_data[sel];
      sram_c.we_n       = stage_we_n[sel];
    end
  end

endmodule

// File: rtl/decode_sequencer.sv
// Runs the M3 -> M2 -> M1 decode stages in order with idle gaps and a per-stage
// timeout, and hands the shared SRAM to whichever stage is running.
module decode_sequencer
  import define_state::*;
#(
  parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = 24'd4000000,
  parameter int unsigned        GAP_CYCLES     = 2
) (
  input  logic                               Clock,
  input  logic                               Resetn,
  input  logic                               Start,
  output logic [NUM_STAGES-1:0]              Stage_enable,
  input  logic [NUM_STAGES-1:0]              Stage_done,
  input  logic [NUM_STAGES-1:0][ADDR_W-1:0]  Stage_SRAM_address,
  input  logic [NUM_STAGES-1:0][DATA_W-1:0]  Stage_SRAM_write_data,
  input  logic [NUM_STAGES-1:0]              Stage_SRAM_we_n,
  output logic [ADDR_W-1:0]                  SRAM_address,
  output logic [DATA_W-1:0]                  SRAM_write_data,
  output logic                               SRAM_we_n,
  output logic [1:0]                         Active_stage,
  output logic                               Busy,
  output logic                               Done,
  output logic                               Error
);

  seq_state_t            state, state_nxt;
  logic [1:0]            idx, idx_nxt;
  logic [TIMER_W-1:0]    timer, timer_nxt;
  logic [GAP_W-1:0]      gap_cnt, gap_nxt;
  logic [NUM_STAGES-1:0] stage_en_nxt;
  logic [1:0]            active_nxt;
  logic                  busy_nxt, done_nxt, err_nxt;
  sram_port_t            sram_c;

  // State, counters and registered outputs
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state        <= S_SEQ_IDLE;
      idx          <= STG_M3;
      timer        <= '0;
      gap_cnt      <= '0;
      Stage_enable <= '0;
      Active_stage <= STG_NONE;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      timer        <= timer_nxt;
      gap_cnt      <= gap_nxt;
      Stage_enable <= stage_en_nxt;
      Active_stage <= active_nxt;
      Busy         <= busy_nxt;
      Done         <= done_nxt;
      Error        <= err_nxt;
    end
  end

  // Next state; a completion in the last timeout cycle wins over the abort
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    timer_nxt = timer;
    gap_nxt   = gap_cnt;
    case (state)
      S_SEQ_IDLE: begin
        if (Start) begin
          idx_nxt   = STG_M3;
          state_nxt = S_SEQ_LAUNCH;
        end
      end
      S_SEQ_LAUNCH: begin
        timer_nxt = '0;
        state_nxt = S_SEQ_WAIT;
      end
      S_SEQ_WAIT: begin
        timer_nxt = timer + TIMER_W'(1);
        if (Stage_done[idx]) begin
          gap_nxt   = '0;
          state_nxt = S_SEQ_GAP;
        end else if (timer == TIMEOUT_CYCLES - TIMER_W'(1)) begin
          state_nxt = S_SEQ_ERROR;
        end
      end
      S_SEQ_GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          gap_nxt = '0;
          if (idx == STG_M1) begin
            state_nxt = S_SEQ_DONE;
          end else begin
            idx_nxt   = idx + 2'd1;
            state_nxt = S_SEQ_LAUNCH;
          end
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      S_SEQ_DONE:  state_nxt = S_SEQ_IDLE;
      S_SEQ_ERROR: state_nxt = S_SEQ_IDLE;
      default:     state_nxt = S_SEQ_IDLE;
    endcase
  end

  // Output values aligned with the state being entered
  always_comb begin
    stage_en_nxt = '0;
    active_nxt   = STG_NONE;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = Error;
    case (state_nxt)
      S_SEQ_LAUNCH: begin
        stage_en_nxt = stage_onehot(idx_nxt);
        busy_nxt     = 1'b1;
      end
      S_SEQ_WAIT: begin
        active_nxt = idx_nxt;
        busy_nxt   = 1'b1;
      end
      S_SEQ_GAP:   busy_nxt = 1'b1;
      S_SEQ_DONE:  done_nxt = 1'b1;
      S_SEQ_ERROR: err_nxt  = 1'b1;
      default: ;
    endcase
    if (state == S_SEQ_IDLE && Start) err_nxt = 1'b0;
  end

  sram_port_mux u_sram_port_mux (
    .sel              (Active_stage),
    .stage_address    (Stage_SRAM_address),
    .stage_write_data (Stage_SRAM_write_data),
    .stage_we_n       (Stage_SRAM_we_n),
    .sram_c           (sram_c)
  );

  assign SRAM_address    = sram_c.address;
  assign SRAM_write_data = sram_c.write_data;
  assign SRAM_we_n       = sram_c.we_n;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: a default-timeout instance for sequencing
// and SRAM muxing, and a short-timeout instance for abort behaviour.
module tb_decode_sequencer;

  logic              Clock = 1'b0;
  logic              Resetn;
  logic              start, t_start;
  logic [2:0]        stage_done, t_done;
  logic [2:0][17:0]  st_addr;
  logic [2:0][15:0]  st_wdata;
  logic [2:0]        st_we_n;

  logic [2:0]  enable, t_enable;
  logic [17:0] sram_addr, t_sram_addr;
  logic [15:0] sram_wdata, t_sram_wdata;
  logic        sram_we_n, t_sram_we_n;
  logic [1:0]  active, t_active;
  logic        busy, done, error, t_busy, t_done_o, t_error;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  decode_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .Start(start),
    .Stage_enable(enable), .Stage_done(stage_done),
    .Stage_SRAM_address(st_addr), .Stage_SRAM_write_data(st_wdata),
    .Stage_SRAM_we_n(st_we_n),
    .SRAM_address(sram_addr), .SRAM_write_data(sram_wdata), .SRAM_we_n(sram_we_n),
    .Active_stage(active), .Busy(busy), .Done(done), .Error(error)
  );

  decode_sequencer #(.TIMEOUT_CYCLES(24'd50), .GAP_CYCLES(2)) dut_to (
    .Clock(Clock), .Resetn(Resetn), .Start(t_start),
    .Stage_enable(t_enable), .Stage_done(t_done),
    .Stage_SRAM_address(st_addr), .Stage_SRAM_write_data(st_wdata),
    .Stage_SRAM_we_n(st_we_n),
    .SRAM_address(t_sram_addr), .SRAM_write_data(t_sram_wdata), .SRAM_we_n(t_sram_we_n),
    .Active_stage(t_active), .Busy(t_busy), .Done(t_done_o), .Error(t_error)
  );

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Runs one stage on dut from its LAUNCH cycle through the gap (and Done if last).
  task automatic stage_cycle(input int idx, input int lat, input bit last);
    logic [2:0] en_exp;
    int bad;
    en_exp = 3'b001 << idx;
    checks++;
    if (enable !== en_exp || busy !== 1'b1) begin
      errors++;
      $display("FAIL launch_stage%0d: enable=%b busy=%b, expected enable=%b busy=1", idx, enable, busy, en_exp);
    end
    bad = 0;
    for (int i = 1; i <= lat; i++) begin
      tick;
      if (enable !== 3'b000 || active !== 2'(idx) || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_stage%0d: %0d bad cycles, expected 0", idx, bad);
    end
    stage_done = en_exp;
    tick;
    stage_done = 3'b000;
    checks++;
    if (active !== 2'd3 || busy !== 1'b1 || enable !== 3'b000) begin
      errors++;
      $display("FAIL gap1_stage%0d: active=%0d busy=%b enable=%b, expected 3 1 000", idx, active, busy, enable);
    end
    tick;
    checks++;
    if (active !== 2'd3 || busy !== 1'b1 || enable !== 3'b000) begin
      errors++;
      $display("FAIL gap2_stage%0d: active=%0d busy=%b enable=%b, expected 3 1 000", idx, active, busy, enable);
    end
    tick;
    if (last) begin
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || enable !== 3'b000) begin
        errors++;
        $display("FAIL done_pulse: done=%b busy=%b error=%b enable=%b, expected 1 0 0 000", done, busy, error, enable);
      end
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_width: done=%b busy=%b, expected 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    tick;
    tick;
    checks++;
    if (enable !== 3'b000 || active !== 2'd3 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: enable=%b active=%0d busy=%b done=%b error=%b, expected 000 3 0 0 0",
               enable, active, busy, done, error);
    end
    checks++;
    if (sram_we_n !== 1'b1 || sram_addr !== 18'd0 || sram_wdata !== 16'd0) begin
      errors++;
      $display("FAIL reset_sram: we_n=%b addr=%0d wdata=%0h, expected 1 0 0", sram_we_n, sram_addr, sram_wdata);
    end
    checks++;
    if (t_error !== 1'b0 || t_active !== 2'd3 || t_sram_we_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_to_inst: error=%b active=%0d we_n=%b, expected 0 3 1", t_error, t_active, t_sram_we_n);
    end
    Resetn = 1'b1;
    tick;
  endtask

  task automatic test_full_decode;
    start = 1'b1;
    tick;
    start = 1'b0;
    stage_cycle(0, 100, 1'b0);
    stage_cycle(1, 200, 1'b0);
    stage_cycle(2, 300, 1'b1);
  endtask

  task automatic test_sram_mux;
    st_addr[0] = 18'd111;  st_wdata[0] = 16'h1111; st_we_n[0] = 1'b0;
    st_addr[2] = 18'd222;  st_wdata[2] = 16'h2222; st_we_n[2] = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    stage_cycle(0, 4, 1'b0);
    tick;
    st_addr[1] = 18'd38400; st_wdata[1] = 16'hBEEF; st_we_n[1] = 1'b0;
    #1;
    checks++;
    if (active !== 2'd1 || sram_addr !== 18'd38400 || sram_we_n !== 1'b0 || sram_wdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL mux_m2: active=%0d addr=%0d we_n=%b wdata=%h, expected 1 38400 0 beef",
               active, sram_addr, sram_we_n, sram_wdata);
    end
    st_addr[0] = 18'd5; st_we_n[0] = 1'b1; st_addr[2] = 18'd7; st_wdata[2] = 16'h7777;
    #1;
    checks++;
    if (sram_addr !== 18'd38400 || sram_we_n !== 1'b0 || sram_wdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL mux_isolation: addr=%0d we_n=%b wdata=%h, expected 38400 0 beef", sram_addr, sram_we_n, sram_wdata);
    end
    st_we_n[0] = 1'b0;
    stage_done = 3'b010;
    tick;
    stage_done = 3'b000;
    checks++;
    if (sram_we_n !== 1'b1 || sram_addr !== 18'd0 || sram_wdata !== 16'd0) begin
      errors++;
      $display("FAIL mux_release: we_n=%b addr=%0d wdata=%h, expected 1 0 0", sram_we_n, sram_addr, sram_wdata);
    end
    tick;
    tick;
    stage_cycle(2, 3, 1'b1);
    st_we_n = 3'b111;
  endtask

  task automatic test_timeout;
    t_start = 1'b1;
    tick;
    t_start = 1'b0;
    tick;
    repeat (49) tick;
    checks++;
    if (t_error !== 1'b0 || t_busy !== 1'b1 || t_active !== 2'd0) begin
      errors++;
      $display("FAIL timeout_early: error=%b busy=%b active=%0d, expected 0 1 0", t_error, t_busy, t_active);
    end
    tick;
    checks++;
    if (t_error !== 1'b1 || t_busy !== 1'b0 || t_active !== 2'd3 || t_enable !== 3'b000 || t_sram_we_n !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: error=%b busy=%b active=%0d enable=%b we_n=%b, expected 1 0 3 000 1",
               t_error, t_busy, t_active, t_enable, t_sram_we_n);
    end
    repeat (5) tick;
    checks++;
    if (t_error !== 1'b1 || t_enable !== 3'b000 || t_busy !== 1'b0 || t_done_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: error=%b enable=%b busy=%b done=%b, expected 1 000 0 0",
               t_error, t_enable, t_busy, t_done_o);
    end
  endtask

  task automatic test_done_priority;
    t_start = 1'b1;
    tick;
    t_start = 1'b0;
    checks++;
    if (t_error !== 1'b0 || t_enable !== 3'b001) begin
      errors++;
      $display("FAIL restart_clears_error: error=%b enable=%b, expected 0 001", t_error, t_enable);
    end
    tick;
    repeat (49) tick;
    t_done = 3'b001;
    tick;
    t_done = 3'b000;
    checks++;
    if (t_error !== 1'b0 || t_busy !== 1'b1 || t_active !== 2'd3) begin
      errors++;
      $display("FAIL priority_gap: error=%b busy=%b active=%0d, expected 0 1 3", t_error, t_busy, t_active);
    end
    tick;
    tick;
    checks++;
    if (t_enable !== 3'b010 || t_error !== 1'b0) begin
      errors++;
      $display("FAIL priority_m2_launch: enable=%b error=%b, expected 010 0", t_enable, t_error);
    end
  endtask

  task automatic test_ignore_spurious;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (enable !== 3'b001) begin
      errors++;
      $display("FAIL spurious_launch: enable=%b, expected 001", enable);
    end
    tick;
    start = 1'b1;
    stage_done = 3'b100;
    tick;
    start = 1'b0;
    stage_done = 3'b000;
    checks++;
    if (active !== 2'd0 || enable !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL spurious_ignored: active=%0d enable=%b busy=%b, expected 0 000 1", active, enable, busy);
    end
    stage_done = 3'b001;
    tick;
    stage_done = 3'b000;
    tick;
    tick;
    stage_cycle(1, 10, 1'b0);
    stage_cycle(2, 10, 1'b1);
  endtask

  task automatic test_reset_mid;
    int bad;
    start = 1'b1;
    tick;
    start = 1'b0;
    stage_cycle(0, 5, 1'b0);
    stage_cycle(1, 5, 1'b0);
    tick;
    st_we_n[2] = 1'b0;
    #1;
    checks++;
    if (active !== 2'd2 || sram_we_n !== 1'b0) begin
      errors++;
      $display("FAIL m1_owns_sram: active=%0d we_n=%b, expected 2 0", active, sram_we_n);
    end
    Resetn = 1'b0;
    tick;
    checks++;
    if (sram_we_n !== 1'b1 || active !== 2'd3 || busy !== 1'b0 || enable !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid: we_n=%b active=%0d busy=%b enable=%b, expected 1 3 0 000",
               sram_we_n, active, busy, enable);
    end
    Resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (enable !== 3'b000 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_quiet: %0d cycles with activity, expected 0", bad);
    end
    st_we_n = 3'b111;
    start = 1'b1;
    tick;
    start = 1'b0;
    stage_cycle(0, 3, 1'b0);
    stage_cycle(1, 3, 1'b0);
    stage_cycle(2, 3, 1'b1);
  endtask

  initial begin
    Resetn     = 1'b0;
    start      = 1'b0;
    t_start    = 1'b0;
    stage_done = 3'b000;
    t_done     = 3'b000;
    st_addr    = '0;
    st_wdata   = '0;
    st_we_n    = 3'b111;
    test_reset();
    test_full_decode();
    test_sram_mux();
    test_timeout();
    test_done_priority();
    test_ignore_spurious();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd4000000, the maximum cycles a stage may run before an abort.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, the number of idle cycles between stages (range 1-15).
REQ-003 SHALL have port Clock, input, 1, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port Resetn, input, 1, the reset, which is synchronous and active-low.
REQ-005 SHALL have port Start, input, 1, a one-cycle pulse that begins a full decode.
REQ-006 SHALL have port Stage_enable, output, 3, one-cycle launch pulses; bit0=M3, bit1=M2, bit2=M1.
REQ-007 SHALL have port Stage_done, input, 3, one-cycle completion pulses from the stages, with the same bit order.
REQ-008 SHALL have port Stage_SRAM_address, input, 3x18, the per-stage SRAM addresses.
REQ-009 SHALL have port Stage_SRAM_write_data, input, 3x16, the per-stage SRAM write data.
REQ-010 SHALL have port Stage_SRAM_we_n, input, 3, the per-stage SRAM write enables (active-low).
REQ-011 SHALL have port SRAM_address, output, 18, the shared SRAM address.
REQ-012 SHALL have port SRAM_write_data, output, 16, the shared SRAM write data.
REQ-013 SHALL have port SRAM_we_n, output, 1, the shared SRAM write enable (active-low).
REQ-014 SHALL have port Active_stage, output, 2: 0=M3, 1=M2, 2=M1, 3=none.
REQ-015 SHALL have port Busy, output, 1, high from Start acceptance until DONE or ERROR is reached.
REQ-016 SHALL have port Done, output, 1, a one-cycle pulse when all stages have completed.
REQ-017 SHALL have port Error, output, 1, a sticky timeout flag.

Function
REQ-018 SHALL have states S_SEQ_IDLE, S_SEQ_LAUNCH, S_SEQ_WAIT, S_SEQ_GAP, S_SEQ_DONE and S_SEQ_ERROR.
REQ-019 SHALL, in IDLE on Start=1, clear Error, set stage index to 0 (M3) and go to LAUNCH.
REQ-020 SHALL, in LAUNCH, assert Stage_enable[idx] for exactly one cycle, set Active_stage=idx, clear the timeout counter and go to WAIT.
REQ-021 SHALL, in WAIT, increment the 24-bit timeout counter each cycle.
REQ-022 SHALL, in WAIT on Stage_done[idx]=1, go to GAP with Active_stage=3 on the next cycle.
REQ-023 SHALL, in GAP, hold for GAP_CYCLES cycles, then go to LAUNCH with idx+1, or to DONE if idx was 2.
REQ-024 SHALL order stages strictly as M3 -> M2 -> M1; idx never wraps.
REQ-025 SHALL, in WAIT when the counter equals TIMEOUT_CYCLES-1 without Stage_done[idx], go to ERROR, set Error=1 and set Active_stage=3.
REQ-026 SHALL give Stage_done[idx] priority over timeout when both occur in the same cycle.
REQ-027 SHALL, in DONE, pulse Done for one cycle and return to IDLE.
REQ-028 SHALL, in ERROR, return to IDLE after one cycle; Error stays 1 until the next accepted Start or reset.
REQ-029 SHALL ignore Start while Busy=1.
REQ-030 SHALL ignore Stage_done bits other than idx, and all Stage_done bits outside WAIT.
REQ-031 SHALL drive SRAM outputs combinationally from the stage selected by registered Active_stage, with zero added latency.
REQ-032 SHALL drive SRAM_address=0, SRAM_write_data=0 and SRAM_we_n=1 when Active_stage=3.
REQ-033 SHALL never drive Stage_enable with more than one bit set.
REQ-034 SHALL set Busy=1 in LAUNCH, WAIT and GAP, and Busy=0 in IDLE, DONE and ERROR.

Reset
REQ-035 SHALL, on Resetn=0 at a rising edge, set state=IDLE, idx=0, counters=0, Active_stage=3, Stage_enable=0, Busy=0, Done=0 and Error=0.
REQ-036 SHALL, on reset mid-decode, release the SRAM (we_n=1) on the following cycle and issue no further Stage_enable pulses.

Structure
REQ-037 SHALL place the sequencer state enum, stage index constants (STG_M3=0, STG_M2=1, STG_M1=2, STG_NONE=3) and SRAM region base addresses in the shared define_state package.
REQ-038 SHALL implement the 3:1 SRAM port multiplexer as sub-module sram_port_mux; the FSM and counters stay in decode_sequencer.

Verification
REQ-039 SHALL cover: Start, stages ack done after 100, 200 and 300 cycles -> enables at M3, M2, M1 in order, each gap 2 cycles, one Done pulse, Error=0.
REQ-040 SHALL cover: M2 active with Stage_SRAM_address[1]=18'd38400, we_n=0 -> SRAM_address=38400, SRAM_we_n=0 in the same cycle; M3/M1 inputs have no effect.
REQ-041 SHALL cover: TIMEOUT_CYCLES=50, M3 never done -> Error=1 at WAIT cycle 50, Active_stage=3, no M2 enable, Busy falls.
REQ-042 SHALL cover: Stage_done[0] on the final timeout cycle -> no Error, M2 launches.
REQ-043 SHALL cover: second Start and a spurious Stage_done[2] during M3 -> both ignored, sequence unchanged.
REQ-044 SHALL cover: Resetn=0 during M1 WAIT -> next cycle SRAM_we_n=1, Active_stage=3, Busy=0; new Start restarts at M3.
